// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one full adder, operands fed LSB-first,
// result assembled by right-shifting sum bits in at the MSB end.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic [1:0]       dbg_state
);

    // Handshake: start is a request honoured only in IDLE (busy low and not
    // in the done cycle); a, b and sub are captured on that same edge. busy
    // is high for exactly WIDTH cycles, then done pulses for one cycle while
    // result/cout/ovf are valid; they hold until the next accepted start.

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_cout;

    always_comb begin
        fa_sum  = op_a[0] ^ op_b[0] ^ carry;
        fa_cout = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
    end

    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_a   <= '0;
            op_b   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtraction is a + ~b + 1: invert b, seed the carry with 1.
                        op_a   <= a;
                        op_b   <= sub ? ~b : b;
                        carry  <= sub;
                        cnt    <= '0;
                        result <= '0;
                        cout   <= 1'b0;
                        ovf    <= 1'b0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    result <= (result >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
                    op_a   <= op_a >> 1;
                    op_b   <= op_b >> 1;
                    carry  <= fa_cout;
                    if (cnt == LAST) begin
                        // carry here is the carry into the MSB position.
                        cout  <= fa_cout;
                        ovf   <= carry ^ fa_cout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: three instances (WIDTH 8, 4, 1) checked against
// a plain-arithmetic model through per-instance expected queues.
module tb_serial_add_ctrl;

    logic       clk;
    logic       rst_n;
    logic       st     [3];
    logic       sb     [3];
    logic [7:0] av     [3];
    logic [7:0] bv     [3];
    logic       busy_w [3];
    logic       done_w [3];
    logic       cout_w [3];
    logic       ovf_w  [3];
    logic [1:0] dbg_w  [3];
    logic [7:0] res8;
    logic [3:0] res4;
    logic [0:0] res1;

    int wid [3] = '{8, 4, 1};
    int cyc;
    int n_cmp;
    int n_bad;
    int busy_cnt [3];

    logic [9:0] exp_q0[$];
    logic [9:0] exp_q1[$];
    logic [9:0] exp_q2[$];
    int         lat_q0[$];
    int         lat_q1[$];
    int         lat_q2[$];

    serial_add_ctrl #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .sub(sb[0]), .a(av[0]), .b(bv[0]),
        .busy(busy_w[0]), .done(done_w[0]), .result(res8), .cout(cout_w[0]),
        .ovf(ovf_w[0]), .dbg_state(dbg_w[0])
    );
    serial_add_ctrl #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .sub(sb[1]), .a(av[1][3:0]), .b(bv[1][3:0]),
        .busy(busy_w[1]), .done(done_w[1]), .result(res4), .cout(cout_w[1]),
        .ovf(ovf_w[1]), .dbg_state(dbg_w[1])
    );
    serial_add_ctrl #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .sub(sb[2]), .a(av[2][0:0]), .b(bv[2][0:0]),
        .busy(busy_w[2]), .done(done_w[2]), .result(res1), .cout(cout_w[2]),
        .ovf(ovf_w[2]), .dbg_state(dbg_w[2])
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Reference: modulo-2^w sum for result/cout, signed range test for ovf.
    function automatic logic [9:0] model(input int w, input longint ua, input longint ub, input bit s);
        longint mask, total, sa, sb2, sr, lo, hi;
        logic [7:0] r;
        logic c, o;
        mask  = (64'sd1 <<< w) - 1;
        ua    = ua & mask;
        ub    = ub & mask;
        total = ua + (s ? (~ub & mask) : ub) + (s ? 1 : 0);
        sa    = (ua >= (64'sd1 <<< (w - 1))) ? ua - (64'sd1 <<< w) : ua;
        sb2   = (ub >= (64'sd1 <<< (w - 1))) ? ub - (64'sd1 <<< w) : ub;
        sr    = s ? sa - sb2 : sa + sb2;
        lo    = -(64'sd1 <<< (w - 1));
        hi    = (64'sd1 <<< (w - 1)) - 1;
        r     = 8'(total & mask);
        c     = ((total >>> w) & 1) != 0;
        o     = (sr < lo) || (sr > hi);
        return {r, c, o};
    endfunction

    function automatic logic [7:0] get_res(input int i);
        case (i)
            0:       return res8;
            1:       return {4'b0, res4};
            default: return {7'b0, res1};
        endcase
    endfunction

    task automatic push(input int i, input logic [9:0] e, input int l);
        case (i)
            0:       begin exp_q0.push_back(e); lat_q0.push_back(l); end
            1:       begin exp_q1.push_back(e); lat_q1.push_back(l); end
            default: begin exp_q2.push_back(e); lat_q2.push_back(l); end
        endcase
    endtask

    task automatic pop(input int i, output logic [9:0] e, output int l, output bit ok);
        ok = 1'b0;
        e  = '0;
        l  = 0;
        case (i)
            0: if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); l = lat_q0.pop_front(); ok = 1'b1; end
            1: if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); l = lat_q1.pop_front(); ok = 1'b1; end
            default: if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); l = lat_q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    // Monitor: every done pulse is matched against the oldest expected entry.
    always @(negedge clk) begin
        logic [9:0] e;
        int         l;
        bit         ok;
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                busy_cnt[i] = 0;
            end else begin
                if (busy_w[i]) busy_cnt[i]++;
                if (done_w[i]) begin
                    pop(i, e, l, ok);
                    if (!ok) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_done w%0d: got done=1 expected no done (cycle %0d)", wid[i], cyc);
                    end else begin
                        chk($sformatf("res_cout_ovf w%0d", wid[i]), {22'b0, get_res(i), cout_w[i], ovf_w[i]}, {22'b0, e});
                        chk($sformatf("done_latency w%0d", wid[i]), cyc, l);
                        chk($sformatf("busy_cycles w%0d", wid[i]), busy_cnt[i], wid[i]);
                    end
                    busy_cnt[i] = 0;
                end
            end
        end
    end

    // Driver: start is set on a falling edge and taken by the next rising edge.
    task automatic issue(input int i, input logic [7:0] ia, input logic [7:0] ib, input logic is, input bit full);
        int w;
        w = wid[i];
        @(negedge clk);
        st[i] = 1'b1;
        av[i] = ia;
        bv[i] = ib;
        sb[i] = is;
        push(i, model(w, longint'(ia), longint'(ib), is), cyc + 1 + w);
        @(negedge clk);
        st[i] = 1'b0;
        av[i] = 8'($urandom);
        bv[i] = 8'($urandom);
        sb[i] = 1'($urandom);
        if (full) repeat (w) @(negedge clk);
    endtask

    task automatic chk_idle_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s busy w%0d", tag, wid[i]), busy_w[i], 0);
            chk($sformatf("%s done w%0d", tag, wid[i]), done_w[i], 0);
            chk($sformatf("%s result w%0d", tag, wid[i]), get_res(i), 0);
            chk($sformatf("%s cout_ovf w%0d", tag, wid[i]), {cout_w[i], ovf_w[i]}, 0);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            st[i] = 1'b0; sb[i] = 1'b0; av[i] = '0; bv[i] = '0; busy_cnt[i] = 0;
        end
        repeat (3) @(negedge clk);
        chk_idle_zero("in_reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle_zero("after_reset");

        // Directed WIDTH=8 cases
        issue(0, 8'd100, 8'd55, 1'b0, 1'b1);
        issue(0, 8'hFF, 8'h01, 1'b0, 1'b1);
        issue(0, 8'h00, 8'h00, 1'b0, 1'b1);
        issue(0, 8'd5, 8'd7, 1'b1, 1'b1);
        issue(0, 8'h80, 8'h01, 1'b1, 1'b1);
        issue(0, 8'h7F, 8'h7F, 1'b0, 1'b1);
        issue(0, 8'h00, 8'h00, 1'b1, 1'b1);

        // Stray start three cycles into RUN must be dropped
        issue(0, 8'h3C, 8'h21, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        st[0] = 1'b1; av[0] = 8'hAA; bv[0] = 8'h55; sb[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (6) @(negedge clk);
        repeat (4) @(negedge clk);

        // Reset in the fourth RUN cycle aborts with no done pulse
        issue(0, 8'h44, 8'h33, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        exp_q0.delete();
        lat_q0.delete();
        #1;
        chk_idle_zero("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        issue(0, 8'h10, 8'h20, 1'b0, 1'b1);

        // Random WIDTH=8 with random gaps
        for (int n = 0; n < 150; n++) begin
            issue(0, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Exhaustive WIDTH=4 and WIDTH=1
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                for (int s = 0; s < 2; s++)
                    issue(1, 8'(x), 8'(y), 1'(s), 1'b1);
        for (int x = 0; x < 2; x++)
            for (int y = 0; y < 2; y++)
                for (int s = 0; s < 2; s++)
                    issue(2, 8'(x), 8'(y), 1'(s), 1'b1);

        repeat (12) @(negedge clk);
        chk("pending w8", exp_q0.size(), 0);
        chk("pending w4", exp_q1.size(), 0);
        chk("pending w1", exp_q2.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial add/subtract sequencer built around a single 1-bit full adder (sum = a^b^c, cout = majority(a,b,c)).
- Accepts two WIDTH-bit operands on a start pulse and feeds them LSB-first through the full adder, one bit per clock.
- Registers the carry between bits and assembles the WIDTH-bit result, carry-out and signed-overflow flag.
- Used wherever area matters more than latency; replaces a WIDTH-bit ripple adder.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- sub  input  1  0 = a+b, 1 = a-b; captured with operands
- a  input  WIDTH  operand A; captured on accepted start
- b  input  WIDTH  operand B; captured on accepted start
- busy  output  1  high while an operation is in progress (RUN state)
- done  output  1  one-cycle pulse: result/cout/ovf valid
- result  output  WIDTH  sum/difference; held until the next accepted start
- cout  output  1  final carry; for sub, 1 = no borrow
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; busy = 0, done = 0, result = 0, cout = 0, ovf = 0.
  - Internal shift registers, carry register and bit counter are cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - On a clock edge with start = 1: capture opA = a and opB = (sub ? ~b : b).
  - Set carry = sub, counter = 0, and clear result/cout/ovf. Go to RUN.
  - With start = 0, stay in IDLE.
- RUN: each edge processes one bit.
  - Full adder inputs: opA[0], opB[0], carry.
  - The sum bit shifts into result at the MSB end; result shifts right by 1.
  - opA and opB shift right by 1; carry takes the full-adder cout.
  - When counter = WIDTH-1, the carry into the bit is also latched as the MSB carry-in. The edge also sets cout = fa_cout, ovf = carry_in_msb XOR fa_cout, and goes to DONE.
  - Otherwise counter increments.
- DONE: done = 1 for exactly one cycle, then unconditionally go to IDLE.
- busy = 1 exactly in RUN, i.e. for WIDTH cycles.
- Latency: start sampled at edge k, bits processed at edges k+1..k+WIDTH, done high in the cycle after edge k+WIDTH.
- Minimum start-to-start interval is WIDTH+2 cycles.
- start while in RUN or DONE is ignored; it is not queued. Operands and sub are sampled only on the accepted edge, so later changes to a, b or sub have no effect.
- result, cout and ovf are stable from the done cycle until the next accepted start. While RUN, result holds partial shift contents and is not valid.
- Arithmetic is modulo 2^WIDTH. Subtraction is a + ~b + 1.
- WIDTH = 1: RUN lasts one cycle; ovf = carry_in XOR cout of the single bit.
- Reset asserted mid-RUN aborts immediately to the reset values. No done pulse is produced. After reset is released, a new start is required.
- rst_n is asynchronous on assertion; release is assumed to be synchronized externally.

Test Plan:
- WIDTH=8: start, sub=0, a=100, b=55 → busy high for 8 cycles; done 8 edges after start; result=155 (0x9B), cout=0, ovf=1.
- WIDTH=8: sub=0, a=0xFF, b=0x01 → result=0x00, cout=1, ovf=0. Follow with a=0x00, b=0x00 → result=0x00, cout=0, ovf=0.
- WIDTH=8 subtract: sub=1, a=5, b=7 → result=0xFE, cout=0 (borrow), ovf=0. Then sub=1, a=0x80, b=0x01 → result=0x7F, cout=1, ovf=1.
- Handshake: pulse start again 3 cycles into RUN with different operands → ignored; first result is unchanged and exactly one done pulse occurs. Change a/b/sub during RUN → no effect on the result.
- Reset mid-op: assert rst_n=0 at RUN cycle 4 → busy=0, done=0, result=0 immediately; no done afterwards. A fresh start with 0x10+0x20 → 0x30.
- Exhaustive WIDTH=1 and WIDTH=4 runs (all a, b, sub combinations) against a reference model → result, cout and ovf match; done latency is exactly WIDTH edges after start every time.
